ball_motion: RTL and testbench

//  Parametrised ball-position engine for the pong datapath. It replaces the fixed 1-px/clk mover.

---
 rtl/ball_pkg.sv | 14 +
 rtl/ball_motion_tick_prescaler.sv | 34 +++
 rtl/ball_motion.sv | 184 ++++++++++++++++++
 tb/tb_ball_motion.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and constants for the pong ball-position engine.
// Imported by the motion FSM and its step prescaler.
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        OUT  = 2'd2
    } ball_state_t;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

endpackage : ball_pkg

// File: rtl/ball_motion_tick_prescaler.sv
// Movement-step strobe generator: counts 0..DIV-1 while enabled and
// raises tick during the cycle whose edge wraps the count back to 0.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_r;

    assign tick = en && (count_r == LAST);

    // Phase counter; frozen whenever the enable is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= '0;
        end else if (en) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule : tick_prescaler

// File: rtl/ball_motion.sv
// Ball-position engine: serve handshake, per-axis speed, prescaled stepping,
// top/bottom wall clamp-reflect, paddle X reflection and left/right miss pulses.
module ball_motion
    import ball_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int SPD_W    = 3,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             serve,
    output logic             serve_ack,
    input  logic             serve_xdir,
    input  logic             serve_ydir,
    input  logic [X_W-1:0]   x_initial,
    input  logic [Y_W-1:0]   y_initial,
    input  logic [SPD_W-1:0] x_speed,
    input  logic [SPD_W-1:0] y_speed,
    input  logic             bounce_x,
    output logic [X_W-1:0]   x_pos,
    output logic [Y_W-1:0]   y_pos,
    output logic             x_dir,
    output logic             y_dir,
    output logic             moving,
    output logic             miss_left,
    output logic             miss_right
);

    localparam logic [X_W-1:0] X_MIN_P = X_W'(X_MIN);
    localparam logic [X_W-1:0] X_MAX_P = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_MIN_P = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] Y_MAX_P = Y_W'(Y_MAX);
    localparam logic [X_W:0]   X_MIN_E = (X_W + 1)'(X_MIN);
    localparam logic [X_W:0]   X_MAX_E = (X_W + 1)'(X_MAX);
    localparam logic [Y_W:0]   Y_MIN_E = (Y_W + 1)'(Y_MIN);
    localparam logic [Y_W:0]   Y_MAX_E = (Y_W + 1)'(Y_MAX);

    ball_state_t      state_r;
    logic [SPD_W-1:0] x_spd_r;
    logic [SPD_W-1:0] y_spd_r;

    logic             presc_reset_s;
    logic             presc_en_s;
    logic             step_s;

    logic             xdir_eff_s;
    logic [X_W:0]     x_ext_s;
    logic [X_W:0]     x_spd_ext_s;
    logic [X_W:0]     nx_s;
    logic             x_under_s;
    logic             x_over_s;

    logic [Y_W:0]     y_ext_s;
    logic [Y_W:0]     y_spd_ext_s;
    logic [Y_W:0]     ny_s;
    logic             y_under_s;
    logic             y_over_s;

    // Holding the prescaler in reset outside MOVE guarantees it starts at 0 after a serve.
    assign presc_reset_s = reset && (state_r == MOVE);
    assign presc_en_s    = (state_r == MOVE) && !pause;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (presc_reset_s),
        .en    (presc_en_s),
        .tick  (step_s)
    );

    assign moving = (state_r == MOVE);

    // X-axis candidate position in one extra bit so a step below zero is caught, not wrapped.
    always_comb begin
        xdir_eff_s  = x_dir ^ bounce_x;
        x_ext_s     = {1'b0, x_pos};
        x_spd_ext_s = {{(X_W + 1 - SPD_W){1'b0}}, x_spd_r};
        if (xdir_eff_s == DIR_POS) begin
            nx_s      = x_ext_s + x_spd_ext_s;
            x_under_s = 1'b0;
            x_over_s  = (nx_s > X_MAX_E);
        end else begin
            nx_s      = x_ext_s - x_spd_ext_s;
            x_under_s = (x_ext_s < (X_MIN_E + x_spd_ext_s));
            x_over_s  = 1'b0;
        end
    end

    // Y-axis candidate position, same extra-bit treatment as X.
    always_comb begin
        y_ext_s     = {1'b0, y_pos};
        y_spd_ext_s = {{(Y_W + 1 - SPD_W){1'b0}}, y_spd_r};
        if (y_dir == DIR_POS) begin
            ny_s      = y_ext_s + y_spd_ext_s;
            y_under_s = 1'b0;
            y_over_s  = (ny_s > Y_MAX_E);
        end else begin
            ny_s      = y_ext_s - y_spd_ext_s;
            y_under_s = (y_ext_s < (Y_MIN_E + y_spd_ext_s));
            y_over_s  = 1'b0;
        end
    end

    // Motion FSM and position/direction registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            x_pos      <= x_initial;
            y_pos      <= y_initial;
            x_dir      <= DIR_NEG;
            y_dir      <= DIR_NEG;
            x_spd_r    <= '0;
            y_spd_r    <= '0;
            serve_ack  <= 1'b0;
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
        end else begin
            serve_ack  <= 1'b0;
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
            case (state_r)
                IDLE: begin
                    x_pos <= x_initial;
                    y_pos <= y_initial;
                    if (serve && !pause) begin
                        serve_ack <= 1'b1;
                        x_dir     <= serve_xdir;
                        y_dir     <= serve_ydir;
                        x_spd_r   <= x_speed;
                        y_spd_r   <= y_speed;
                        state_r   <= MOVE;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                MOVE: begin
                    if (step_s) begin
                        x_dir <= xdir_eff_s;
                        if (x_under_s) begin
                            x_pos     <= X_MIN_P;
                            miss_left <= 1'b1;
                            state_r   <= OUT;
                        end else if (x_over_s) begin
                            x_pos      <= X_MAX_P;
                            miss_right <= 1'b1;
                            state_r    <= OUT;
                        end else begin
                            x_pos <= nx_s[X_W-1:0];
                        end
                        // Wall hits clamp onto the wall and flip direction; no overshoot fold.
                        if (y_under_s) begin
                            y_pos <= Y_MIN_P;
                            y_dir <= DIR_POS;
                        end else if (y_over_s) begin
                            y_pos <= Y_MAX_P;
                            y_dir <= DIR_NEG;
                        end else begin
                            y_pos <= ny_s[Y_W-1:0];
                        end
                    end else begin
                        state_r <= MOVE;
                    end
                end
                OUT: begin
                    x_pos   <= x_initial;
                    y_pos   <= y_initial;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule : ball_motion

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: a cycle-level integer model checked on
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_ball_motion;

    localparam int X_W      = 10;
    localparam int Y_W      = 10;
    localparam int SPD_W    = 3;
    localparam int X_MIN    = 0;
    localparam int X_MAX    = 639;
    localparam int Y_MIN    = 0;
    localparam int Y_MAX    = 479;
    localparam int TICK_DIV = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             pause;
    logic             serve;
    logic             serve_ack;
    logic             serve_xdir;
    logic             serve_ydir;
    logic [X_W-1:0]   x_initial;
    logic [Y_W-1:0]   y_initial;
    logic [SPD_W-1:0] x_speed;
    logic [SPD_W-1:0] y_speed;
    logic             bounce_x;
    logic [X_W-1:0]   x_pos;
    logic [Y_W-1:0]   y_pos;
    logic             x_dir;
    logic             y_dir;
    logic             moving;
    logic             miss_left;
    logic             miss_right;

    always #5 clk = ~clk;

    ball_motion #(
        .X_W(X_W), .Y_W(Y_W), .SPD_W(SPD_W),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk), .reset(reset), .pause(pause), .serve(serve),
        .serve_ack(serve_ack), .serve_xdir(serve_xdir), .serve_ydir(serve_ydir),
        .x_initial(x_initial), .y_initial(y_initial),
        .x_speed(x_speed), .y_speed(y_speed), .bounce_x(bounce_x),
        .x_pos(x_pos), .y_pos(y_pos), .x_dir(x_dir), .y_dir(y_dir),
        .moving(moving), .miss_left(miss_left), .miss_right(miss_right)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle, 1=moving, 2=miss cycle; phase counts clocks toward the next step.
    int m_mode, m_phase, m_x, m_y, m_xs, m_ys, m_xd, m_yd;
    int m_ack, m_ml, m_mr;
    bit m_valid = 1'b0;

    initial begin
        int nx, ny;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_mode = 0; m_phase = 0; m_x = x_initial; m_y = y_initial;
                m_xd = 0; m_yd = 0; m_xs = 0; m_ys = 0;
                m_ack = 0; m_ml = 0; m_mr = 0;
            end else begin
                m_ack = 0; m_ml = 0; m_mr = 0;
                if (m_mode == 0) begin
                    m_x = x_initial; m_y = y_initial;
                    if (serve && !pause) begin
                        m_ack = 1; m_mode = 1; m_phase = 0;
                        m_xd = serve_xdir; m_yd = serve_ydir;
                        m_xs = x_speed; m_ys = y_speed;
                    end
                end else if (m_mode == 1) begin
                    if (!pause) begin
                        m_phase = (m_phase + 1) % TICK_DIV;
                        if (m_phase == 0) begin
                            m_xd = m_xd ^ int'(bounce_x);
                            nx = (m_xd == 1) ? m_x + m_xs : m_x - m_xs;
                            ny = (m_yd == 1) ? m_y + m_ys : m_y - m_ys;
                            if (nx < X_MIN) begin
                                m_x = X_MIN; m_ml = 1; m_mode = 2;
                            end else if (nx > X_MAX) begin
                                m_x = X_MAX; m_mr = 1; m_mode = 2;
                            end else begin
                                m_x = nx;
                            end
                            if (ny < Y_MIN) begin
                                m_y = Y_MIN; m_yd = 1;
                            end else if (ny > Y_MAX) begin
                                m_y = Y_MAX; m_yd = 0;
                            end else begin
                                m_y = ny;
                            end
                        end
                    end
                end else begin
                    m_x = x_initial; m_y = y_initial; m_mode = 0;
                end
            end
            m_valid = 1'b1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("m_x_pos", 32'(x_pos), m_x);
                chk("m_y_pos", 32'(y_pos), m_y);
                chk("m_x_dir", 32'(x_dir), m_xd);
                chk("m_y_dir", 32'(y_dir), m_yd);
                chk("m_moving", 32'(moving), (m_mode == 1) ? 1 : 0);
                chk("m_serve_ack", 32'(serve_ack), m_ack);
                chk("m_miss_left", 32'(miss_left), m_ml);
                chk("m_miss_right", 32'(miss_right), m_mr);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_serve(input int xi, input int yi, input int xs, input int ys,
                             input bit xd, input bit yd);
        x_initial  = X_W'(xi);
        y_initial  = Y_W'(yi);
        x_speed    = SPD_W'(xs);
        y_speed    = SPD_W'(ys);
        serve_xdir = xd;
        serve_ydir = yd;
    endtask

    initial begin
        reset = 1'b0; pause = 1'b0; serve = 1'b0; bounce_x = 1'b0;
        set_serve(320, 240, 2, 1, 1'b1, 1'b1);
        clks(3);
        chk("rst_x", 32'(x_pos), 320);
        chk("rst_y", 32'(y_pos), 240);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_ack", 32'(serve_ack), 0);
        chk("rst_xdir", 32'(x_dir), 0);

        // Serve is not accepted while paused.
        reset = 1'b1; pause = 1'b1; serve = 1'b1;
        clks(2);
        chk("paused_serve_moving", 32'(moving), 0);
        chk("paused_serve_ack", 32'(serve_ack), 0);

        // Serve handshake and first step.
        pause = 1'b0;
        clks(1);
        chk("serve_ack", 32'(serve_ack), 1);
        chk("serve_moving", 32'(moving), 1);
        serve = 1'b0;
        clks(1);
        chk("serve_ack_once", 32'(serve_ack), 0);
        clks(3);
        chk("step1_x", 32'(x_pos), 322);
        chk("step1_y", 32'(y_pos), 241);

        // Pause two clocks into a step period; bounce_x must be ignored.
        clks(2);
        pause = 1'b1; bounce_x = 1'b1;
        clks(20);
        chk("pause_x", 32'(x_pos), 322);
        chk("pause_y", 32'(y_pos), 241);
        chk("pause_xdir", 32'(x_dir), 1);
        pause = 1'b0; bounce_x = 1'b0;
        clks(1);
        chk("resume_x_hold", 32'(x_pos), 322);
        clks(1);
        chk("resume_x_step", 32'(x_pos), 324);
        chk("resume_y_step", 32'(y_pos), 242);

        // Reset mid-flight.
        reset = 1'b0;
        clks(1);
        chk("midrst_moving", 32'(moving), 0);
        chk("midrst_x", 32'(x_pos), 320);
        chk("midrst_y", 32'(y_pos), 240);
        chk("midrst_ack", 32'(serve_ack), 0);
        reset = 1'b1;

        // Paddle bounce on the step cycle.
        set_serve(100, 240, 2, 0, 1'b1, 1'b1);
        serve = 1'b1;
        clks(1);
        serve = 1'b0;
        clks(3);
        bounce_x = 1'b1;
        clks(1);
        bounce_x = 1'b0;
        chk("paddle_x", 32'(x_pos), 98);
        chk("paddle_xdir", 32'(x_dir), 0);
        chk("paddle_y", 32'(y_pos), 240);

        // Bottom wall clamp-reflect.
        reset = 1'b0;
        clks(1);
        reset = 1'b1;
        set_serve(320, 478, 0, 1, 1'b1, 1'b1);
        serve = 1'b1;
        clks(1);
        serve = 1'b0;
        clks(4);
        chk("wall1_y", 32'(y_pos), 479);
        chk("wall1_ydir", 32'(y_dir), 1);
        clks(4);
        chk("wall2_y", 32'(y_pos), 479);
        chk("wall2_ydir", 32'(y_dir), 0);
        clks(4);
        chk("wall3_y", 32'(y_pos), 478);
        chk("wall3_x", 32'(x_pos), 320);

        // Left miss.
        reset = 1'b0;
        clks(1);
        reset = 1'b1;
        set_serve(1, 240, 3, 0, 1'b0, 1'b1);
        serve = 1'b1;
        clks(1);
        serve = 1'b0;
        clks(4);
        chk("lmiss_x", 32'(x_pos), 0);
        chk("lmiss_pulse", 32'(miss_left), 1);
        chk("lmiss_moving", 32'(moving), 0);
        clks(1);
        chk("lmiss_pulse_end", 32'(miss_left), 0);
        chk("lmiss_reload_x", 32'(x_pos), 1);
        chk("lmiss_idle", 32'(moving), 0);

        // Right miss together with a top-wall bounce in the same step.
        set_serve(637, 0, 3, 2, 1'b1, 1'b0);
        serve = 1'b1;
        clks(1);
        serve = 1'b0;
        clks(4);
        chk("rmiss_x", 32'(x_pos), 639);
        chk("rmiss_pulse", 32'(miss_right), 1);
        chk("rmiss_no_left", 32'(miss_left), 0);
        chk("rmiss_y", 32'(y_pos), 0);
        chk("rmiss_ydir", 32'(y_dir), 1);
        clks(1);
        chk("rmiss_pulse_end", 32'(miss_right), 0);
        chk("rmiss_idle", 32'(moving), 0);
        chk("rmiss_reload_y", 32'(y_pos), 0);

        clks(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ball_motion
